// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: control bundle bit map
// and register-index helpers.
package riscv_pipe_pkg;

  localparam int unsigned CTRL_W = 8;

  localparam int unsigned REG_WRITE  = 0;
  localparam int unsigned MEM_READ   = 1;
  localparam int unsigned MEM_WRITE  = 2;
  localparam int unsigned MEM_TO_REG = 3;
  localparam int unsigned ALU_SRC    = 4;
  localparam int unsigned BRANCH     = 5;
  localparam int unsigned JUMP       = 6;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

  // True when the WB write lands on the register being read; x0 never matches.
  function automatic logic wb_hits(input logic we, input reg_idx_t wb_rd,
                                   input reg_idx_t rs);
    return we && (wb_rd != ZERO_REG) && (wb_rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-to-EX bundle: decoded fields from ID and the registered EX-slot view.
interface id_ex_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 8
);
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [CTRL_W-1:0] id_ctrl;

  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_imm;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_ctrl,
    input  ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_ctrl,
    output ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection and fetch-stall generation.
module hazard_detect
  import riscv_pipe_pkg::*;
(
  input  logic     id_valid,
  input  reg_idx_t id_rs1,
  input  reg_idx_t id_rs2,
  input  logic     id_uses_rs1,
  input  logic     id_uses_rs2,
  input  logic     ex_valid,
  input  logic     ex_mem_read,
  input  reg_idx_t ex_rd,
  input  logic     ex_flush,
  input  logic     mem_stall,
  output logic     load_use_hazard,
  output logic     stall_fetch
);

  logic rs1_dep;
  logic rs2_dep;

  always_comb begin
    rs1_dep         = id_uses_rs1 && (ex_rd == id_rs1);
    rs2_dep         = id_uses_rs2 && (ex_rd == id_rs2);
    load_use_hazard = id_valid && ex_valid && ex_mem_read &&
                      (ex_rd != ZERO_REG) && (rs1_dep || rs2_dep);
    // A taken branch squashes the dependent instruction, so fetch may proceed.
    stall_fetch     = (load_use_hazard && !ex_flush) || mem_stall;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, MEM hold,
// WB write-through bypass and a saturating load-use bubble counter.
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = riscv_pipe_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_if.slave           bus,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             ex_flush,
  input  logic             mem_stall,
  output logic             load_use_hazard,
  output logic             stall_fetch,
  output logic [CNT_W-1:0] bubble_count
);

  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_imm;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  reg_idx_t          ex_rs1;
  reg_idx_t          ex_rs2;
  reg_idx_t          ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              insert_bubble;

  hazard_detect u_hazard (
    .id_valid        (bus.id_valid),
    .id_rs1          (bus.id_rs1),
    .id_rs2          (bus.id_rs2),
    .id_uses_rs1     (bus.id_uses_rs1),
    .id_uses_rs2     (bus.id_uses_rs2),
    .ex_valid        (ex_valid),
    .ex_mem_read     (ex_ctrl[MEM_READ]),
    .ex_rd           (ex_rd),
    .ex_flush        (ex_flush),
    .mem_stall       (mem_stall),
    .load_use_hazard (load_use_hazard),
    .stall_fetch     (stall_fetch)
  );

  assign insert_bubble = ex_flush || load_use_hazard || !bus.id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ctrl     <= '0;
    end else if (!mem_stall) begin
      if (insert_bubble) begin
        ex_valid    <= 1'b0;
        ex_pc       <= '0;
        ex_imm      <= '0;
        ex_rs1_data <= '0;
        ex_rs2_data <= '0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rd       <= '0;
        ex_ctrl     <= '0;
      end else begin
        ex_valid    <= 1'b1;
        ex_pc       <= bus.id_pc;
        ex_imm      <= bus.id_imm;
        ex_rs1_data <= wb_hits(wb_reg_write, wb_rd, bus.id_rs1) ? wb_data : bus.id_rs1_data;
        ex_rs2_data <= wb_hits(wb_reg_write, wb_rd, bus.id_rs2) ? wb_data : bus.id_rs2_data;
        ex_rs1      <= bus.id_rs1;
        ex_rs2      <= bus.id_rs2;
        ex_rd       <= bus.id_rd;
        ex_ctrl     <= bus.id_ctrl;
      end
    end
  end

  // Only hazard bubbles count; a coincident flush takes the bubble instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
    end else if (!mem_stall && !ex_flush && load_use_hazard && (bubble_count != '1)) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

  assign bus.ex_valid    = ex_valid;
  assign bus.ex_pc       = ex_pc;
  assign bus.ex_imm      = ex_imm;
  assign bus.ex_rs1_data = ex_rs1_data;
  assign bus.ex_rs2_data = ex_rs2_data;
  assign bus.ex_rs1      = ex_rs1;
  assign bus.ex_rs2      = ex_rs2;
  assign bus.ex_rd       = ex_rd;
  assign bus.ex_ctrl     = ex_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a slot-level model.
module tb_id_ex_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned CNT_W  = 2;
  localparam int          CNT_MAX = 3;

  logic             clk;
  logic             rst_n;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             ex_flush;
  logic             mem_stall;
  logic             load_use_hazard;
  logic             stall_fetch;
  logic [CNT_W-1:0] bubble_count;

  id_ex_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus.slave),
    .wb_reg_write    (wb_reg_write),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .ex_flush        (ex_flush),
    .mem_stall       (mem_stall),
    .load_use_hazard (load_use_hazard),
    .stall_fetch     (stall_fetch),
    .bubble_count    (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   d1;
    logic [XLEN-1:0]   d2;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } slot_t;

  localparam logic [CTRL_W-1:0] LW  = 8'h0B;
  localparam logic [CTRL_W-1:0] ADD = 8'h01;

  slot_t m;
  int    m_cnt;
  int    checks;
  int    errors;

  function automatic slot_t obs();
    return {bus.ex_valid, bus.ex_pc, bus.ex_imm, bus.ex_rs1_data, bus.ex_rs2_data,
            bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_ctrl};
  endfunction

  // Model: an instruction in ID may not enter EX while a load in EX writes a register it reads.
  function automatic logic m_hazard();
    logic reads_load_dest;
    reads_load_dest = (bus.id_uses_rs1 && bus.id_rs1 == m.rd) ||
                      (bus.id_uses_rs2 && bus.id_rs2 == m.rd);
    return bus.id_valid && m.valid && m.ctrl[1] && m.rd != 0 && reads_load_dest;
  endfunction

  function automatic logic m_stall_fetch();
    return (m_hazard() && !ex_flush) || mem_stall;
  endfunction

  function automatic logic [XLEN-1:0] reg_read(input logic [4:0] idx, input logic [XLEN-1:0] rf);
    if (wb_reg_write && wb_rd != 0 && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  task automatic step();
    logic hz;
    hz = m_hazard();
    @(posedge clk);
    if (mem_stall) begin
      // frozen
    end else if (ex_flush) begin
      m = '0;
    end else if (hz) begin
      m = '0;
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end else if (!bus.id_valid) begin
      m = '0;
    end else begin
      m = '{valid: 1'b1, pc: bus.id_pc, imm: bus.id_imm,
            d1: reg_read(bus.id_rs1, bus.id_rs1_data),
            d2: reg_read(bus.id_rs2, bus.id_rs2_data),
            rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd, ctrl: bus.id_ctrl};
    end
    #1;
  endtask

  task automatic set_id(input logic v, input logic [XLEN-1:0] pc,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2,
                        input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                        input logic [XLEN-1:0] imm, input logic [CTRL_W-1:0] ctrl);
    bus.id_valid = v;       bus.id_pc = pc;
    bus.id_rs1 = rs1;       bus.id_rs2 = rs2;      bus.id_rd = rd;
    bus.id_uses_rs1 = u1;   bus.id_uses_rs2 = u2;
    bus.id_rs1_data = d1;   bus.id_rs2_data = d2;
    bus.id_imm = imm;       bus.id_ctrl = ctrl;
  endtask

  task automatic set_ctl(input logic flush, input logic stall, input logic we,
                         input logic [4:0] rd, input logic [XLEN-1:0] data);
    ex_flush = flush; mem_stall = stall;
    wb_reg_write = we; wb_rd = rd; wb_data = data;
  endtask

  task automatic test_reset();
    set_ctl(0, 0, 0, 0, 0);
    set_id(1, 32'h100, 1, 2, 5, 1, 1, 32'h1111, 32'h2222, 32'h44, LW);
    step();
    set_id(1, 32'h104, 5, 7, 6, 1, 1, 32'h3333, 32'h4444, 32'h8, ADD);
    step();
    step();
    checks++;
    if (obs() !== m || bubble_count !== CNT_W'(m_cnt)) begin
      errors++; $display("FAIL pre_reset_state: got %h cnt %0d, expected %h cnt %0d", obs(), bubble_count, m, m_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    m = '0; m_cnt = 0;
    checks++;
    if (obs() !== slot_t'(0)) begin
      errors++; $display("FAIL async_reset_slot: got %h, expected 0", obs());
    end
    checks++;
    if (bubble_count !== '0) begin
      errors++; $display("FAIL async_reset_count: got %0d, expected 0", bubble_count);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    set_ctl(0, 0, 0, 0, 0);
    set_id(1, 32'h200, 1, 2, 5, 1, 1, 32'h10, 32'h20, 32'h4, LW);
    step();
    set_id(1, 32'h204, 5, 7, 6, 1, 1, 32'h55, 32'h77, 32'h0, ADD);
    #1;
    checks++;
    if (load_use_hazard !== 1'b1 || stall_fetch !== 1'b1) begin
      errors++; $display("FAIL load_use_detect: got hz %b sf %b, expected 1 1", load_use_hazard, stall_fetch);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_rd !== 5'd0 || bubble_count !== 2'd1) begin
      errors++; $display("FAIL load_use_bubble: got v %b rd %0d cnt %0d, expected 0 0 1", bus.ex_valid, bus.ex_rd, bubble_count);
    end
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL load_use_clears: got %b, expected 0", load_use_hazard);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rs1 !== 5'd5 || bus.ex_pc !== 32'h204) begin
      errors++; $display("FAIL load_use_dependent: got v %b rs1 %0d pc %h, expected 1 5 204", bus.ex_valid, bus.ex_rs1, bus.ex_pc);
    end
  endtask

  task automatic test_no_false_hazard();
    set_id(1, 32'h300, 1, 2, 0, 1, 1, 0, 0, 0, LW);
    step();
    set_id(1, 32'h304, 0, 3, 8, 1, 1, 0, 0, 0, ADD);
    #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL no_hazard_x0: got %b, expected 0", load_use_hazard);
    end
    set_id(1, 32'h308, 1, 2, 5, 1, 1, 0, 0, 0, LW);
    step();
    set_id(1, 32'h30C, 3, 5, 8, 1, 0, 0, 0, 0, ADD);
    #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++; $display("FAIL no_hazard_unused_rs2: got %b, expected 0", load_use_hazard);
    end
    step();
  endtask

  task automatic test_flush_priority();
    int cnt_before;
    set_id(1, 32'h400, 1, 2, 5, 1, 1, 0, 0, 0, LW);
    step();
    cnt_before = m_cnt;
    set_id(1, 32'h404, 5, 7, 6, 1, 1, 0, 0, 0, ADD);
    ex_flush = 1'b1;
    #1;
    checks++;
    if (load_use_hazard !== 1'b1 || stall_fetch !== 1'b0) begin
      errors++; $display("FAIL flush_comb: got hz %b sf %b, expected 1 0", load_use_hazard, stall_fetch);
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b0 || obs() !== slot_t'(0) || bubble_count !== CNT_W'(cnt_before)) begin
      errors++; $display("FAIL flush_bubble: got v %b cnt %0d, expected 0 %0d", bus.ex_valid, bubble_count, cnt_before);
    end
    ex_flush = 1'b0;
  endtask

  task automatic test_mem_stall();
    slot_t snap;
    logic [1:0] cnt_snap;
    set_id(1, 32'h500, 3, 4, 9, 1, 1, 32'hA, 32'hB, 32'hC, ADD);
    step();
    snap = m;
    cnt_snap = bubble_count;
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1, 1,
             $urandom, $urandom, $urandom, 8'($urandom));
      #1;
      checks++;
      if (stall_fetch !== 1'b1) begin
        errors++; $display("FAIL stall_fetch_on_mem_stall: got %b, expected 1", stall_fetch);
      end
      step();
      checks++;
      if (obs() !== snap || bubble_count !== cnt_snap) begin
        errors++; $display("FAIL mem_stall_hold: got %h, expected %h", obs(), snap);
      end
    end
    mem_stall = 1'b0;
    set_id(1, 32'h5A0, 6, 7, 10, 1, 1, 32'h61, 32'h71, 32'h81, ADD);
    step();
    checks++;
    if (obs() !== m || bus.ex_pc !== 32'h5A0) begin
      errors++; $display("FAIL mem_stall_release: got %h, expected %h", obs(), m);
    end
  endtask

  task automatic test_bypass();
    set_id(1, 32'h600, 9, 3, 10, 1, 1, 32'h11, 32'h22, 0, ADD);
    set_ctl(0, 0, 1, 9, 32'hDEADBEEF);
    step();
    checks++;
    if (bus.ex_rs1_data !== 32'hDEADBEEF || bus.ex_rs2_data !== 32'h22) begin
      errors++; $display("FAIL bypass_rs1: got %h %h, expected deadbeef 00000022", bus.ex_rs1_data, bus.ex_rs2_data);
    end
    wb_rd = 5'd0;
    set_id(1, 32'h604, 0, 0, 10, 1, 1, 32'h11, 32'h22, 0, ADD);
    step();
    checks++;
    if (bus.ex_rs1_data !== 32'h11 || bus.ex_rs2_data !== 32'h22) begin
      errors++; $display("FAIL bypass_x0: got %h %h, expected 00000011 00000022", bus.ex_rs1_data, bus.ex_rs2_data);
    end
    set_ctl(0, 0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      set_id(1, 32'h700 + 8 * i, 1, 2, 5, 1, 1, 0, 0, 0, LW);
      step();
      set_id(1, 32'h704 + 8 * i, 3, 5, 6, 0, 1, 0, 0, 0, ADD);
      step();
    end
    checks++;
    if (bubble_count !== 2'd3 || m_cnt != CNT_MAX) begin
      errors++; $display("FAIL counter_saturation: got %0d, expected 3", bubble_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_id(($urandom_range(0, 9) != 0), $urandom, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             {5'($urandom), 1'($urandom), ($urandom_range(0, 9) < 4), 1'($urandom)});
      set_ctl(($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0), 1'($urandom),
              5'($urandom_range(0, 7)), $urandom);
      #1;
      checks++;
      if (load_use_hazard !== m_hazard() || stall_fetch !== m_stall_fetch()) begin
        errors++; $display("FAIL random_comb[%0d]: got hz %b sf %b, expected %b %b", i, load_use_hazard, stall_fetch, m_hazard(), m_stall_fetch());
      end
      step();
      checks++;
      if (obs() !== m || bubble_count !== CNT_W'(m_cnt)) begin
        errors++; $display("FAIL random_slot[%0d]: got %h cnt %0d, expected %h cnt %0d", i, obs(), bubble_count, m, m_cnt);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    m = '0; m_cnt = 0;
    rst_n = 1'b0;
    set_ctl(0, 0, 0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12 rst_n = 1'b1;
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_flush_priority();
    test_mem_stall();
    test_bypass();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32 core, with load-use hazard detection and register-file write-through bypass.
- Captures decoded operands and control from ID and presents registered EX_rs1/EX_rs2 plus operand data to the EX stage forwarding mux and ALU.
- Inserts bubbles on load-use hazards and on branch flushes; holds on MEM back-pressure.

Parameters:
- XLEN, 32, datapath and PC width.
- CTRL_W, 8, width of the packed control bundle (bit map in package).
- CNT_W, 16, width of the load-use bubble performance counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
- id_imm  in  XLEN  decoded immediate
- id_ctrl  in  CTRL_W  control bundle
- wb_reg_write  in  1  WB writes the register file this cycle
- wb_rd  in  5  WB destination
- wb_data  in  XLEN  WB write data
- ex_flush  in  1  branch/jump taken in EX; squash ID
- mem_stall  in  1  MEM back-pressure; freeze ID/EX
- ex_valid  out  1  EX slot valid
- ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  out  XLEN each  registered fields
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices
- ex_ctrl  out  CTRL_W  registered control
- load_use_hazard  out  1  combinational; ID must not advance
- stall_fetch  out  1  combinational; hold PC and IF/ID
- bubble_count  out  CNT_W  saturating load-use bubble count

Behaviour:
- Reset (async, rst_n=0): every registered output is 0, including ex_valid, indices, ctrl, data, and bubble_count.
- load_use_hazard = id_valid & ex_valid & ex_ctrl[MEM_READ] & (ex_rd!=0) & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- stall_fetch = (load_use_hazard & ~ex_flush) | mem_stall.
- Per-clock update uses strict priority:
  1. mem_stall: hold every register unchanged. The counter does not change.
  2. ex_flush: insert a bubble.
  3. load_use_hazard: insert a bubble; bubble_count += 1, saturating at all-ones.
  4. Otherwise load ID fields. ex_valid=id_valid. If id_valid=0, load a bubble instead.
- Bubble: ex_valid=0, and ex_ctrl, ex_rd, ex_rs1, ex_rs2, ex_pc, ex_imm, ex_rs1_data and ex_rs2_data are all 0. Zero indices guarantee no downstream forwarding match.
- Write-through bypass, applied on load only:
  - If wb_reg_write & wb_rd!=0 & wb_rd==id_rs1, capture wb_data into ex_rs1_data; else capture id_rs1_data.
  - Same rule for rs2.
  - x0 is never bypassed.
- Latency: one cycle from ID inputs to ex_* outputs. A load-use hazard costs exactly one bubble. The dependent instruction loads on the following cycle, since the load has moved to MEM and the hazard clears.
- A flush coincident with a hazard gives one bubble, and the counter is not incremented.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Decomposition:
- Package riscv_pipe_pkg:
  - CTRL_W.
  - Control bit indices: REG_WRITE=0, MEM_READ=1, MEM_WRITE=2, MEM_TO_REG=3, ALU_SRC=4, BRANCH=5, JUMP=6, spare=7.
  - ZERO_REG=5'd0.
- Sub-module hazard_detect: purely combinational load_use_hazard/stall_fetch.
- The register bank with priority mux and counter stays in id_ex_stage.

Test Plan:
- Reset: drive ID fields nonzero, rst_n=0 mid-cycle -> all ex_* and bubble_count go to 0 without waiting for clk.
- Load-use: EX=lw x5 (MEM_READ=1, rd=5), ID=add x6,x5,x7 (uses_rs1=1) -> load_use_hazard=1 and stall_fetch=1; next cycle ex_valid=0, ex_rd=0, bubble_count=1; the cycle after, add loads with ex_rs1=5.
- No false hazard:
  - EX=lw x0 with ID rs1=0 -> hazard=0.
  - EX=lw x5 with ID uses_rs2=0 and rs2=5 -> hazard=0.
- Flush priority: ex_flush=1 together with a load-use condition -> bubble inserted, bubble_count unchanged, stall_fetch=0.
- mem_stall: hold 3 cycles with changing ID inputs -> ex_* constant; release -> ID loads on the first non-stall edge.
- Bypass: id_rs1=9, id_rs1_data=0x11, wb_reg_write=1, wb_rd=9, wb_data=0xDEADBEEF -> ex_rs1_data=0xDEADBEEF. With wb_rd=0 -> 0x11.
- Counter saturation: CNT_W=2, five hazards -> bubble_count stays at 3.
